cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Exception and interrupt controller with a minimal CP0 register file for the interrupt-capable pipelined CPU. It sits directly downstream of the EX-stage overflow qualifier and consumes its qualified overflow flag alongside the EX-stage instruction. It decodes SYSCALL, ERET, MTC0 and MFC0, and samples external interrupts. When an event is taken it records EPC and Cause, then issues a one-cycle pipeline flush with a PC redirect.

## Interface
- EXC_VEC, 32'h0000_0080, exception/interrupt handler entry PC
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_ex_i  in  1  EX holds a real instruction (0 = bubble)
- ir_ex_i  in  32  EX-stage instruction word
- pc_ex_i  in  32  EX-stage instruction PC
- overflow_i  in  1  qualified add/sub overflow for the EX instruction
- hw_int_i  in  6  level-sensitive external interrupt lines
- wdata_i  in  32  rt operand for MTC0
- rdata_o  out  32  MFC0 read data (combinational on ir_ex_i[15:11])
- flush_o  out  1  squash IF, ID, EX and MEM contents
- redirect_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  target PC

## Operation
- Registers:
  - Status (12): IM[15:8], EXL bit1, IE bit0.
  - Cause (13): IP[15:8], ExcCode[6:2]; IP[15:10] mirrors hw_int_i every cycle.
  - EPC (14).
- Decode:
  - MTC0: ir[31:21]=11'h204.
  - MFC0: ir[31:21]=11'h200.
  - ERET: ir=32'h4200_0018.
  - SYSCALL: ir[31:26]=0, ir[5:0]=6'h0C.
- Event evaluation happens in state RUN with valid_ex_i=1. Priority is overflow (ExcCode 12), then SYSCALL (8), then interrupt (0).
- An interrupt is pending when `|(IP & IM)` is true, IE=1 and EXL=0.
- Taking an event:
  - EPC ← pc_ex_i. The faulting or interrupted instruction is not completed; an interrupt restarts it.
  - ExcCode is written and EXL ← 1.
  - The FSM moves to FLUSH with redirect_pc_o ← EXC_VEC.
- ERET with EXL=1: EXL ← 0, redirect_pc_o ← EPC, move to FLUSH. ERET with EXL=0 is a no-op.
- MTC0 writes Status or EPC; writes to Cause, other than IP[9:8] (software interrupts), are ignored. MTC0 does not execute in a cycle where an event is taken.
- MFC0 to an unimplemented register reads 0.
- FSM states:
  - RUN → FLUSH on a taken event or a valid ERET.
  - FLUSH → RUN unconditionally.
  - Events and MTC0 writes are ignored while in FLUSH.

## Timing
- Reset values: all CP0 registers 0, flush_o=0, redirect_o=0, redirect_pc_o=0, FSM in RUN.
- Detection in cycle N is registered. flush_o and redirect_o are both high for exactly one cycle, N+1, with a stable redirect_pc_o.
- CP0 register updates from an event, ERET or MTC0 are visible from cycle N+1.
- Pending interrupts are re-evaluated every RUN cycle. A line deasserted before a valid EX cycle is never taken.
- An event on a bubble cycle waits for the next valid instruction.
- Reset asserted during FLUSH aborts the flush immediately; all outputs drop to 0.

## Configuration
- CP0_TIMER_EN defined:
  - Count (9) increments every cycle and wraps 0xFFFF_FFFF→0.
  - Compare (11) is readable and writable by MTC0/MFC0.
  - Count==Compare sets Cause.IP7, which stays set until the next MTC0 to Compare.
  - Cause.IP7 then overrides hw_int_i[5].
- CP0_TIMER_EN undefined:
  - No Count/Compare registers; both read 0.
  - IP7 follows hw_int_i[5].

## Structure
- Package pcpu_cp0_pkg: CP0 register indices, ExcCode constants (EXC_INT, EXC_SYS, EXC_OV), decode patterns, Status/Cause bit positions, FSM state enum.
- Sub-module cp0_timer (Count/Compare/IP7 logic), instantiated only under CP0_TIMER_EN.

## Test plan
- Overflow: pc_ex_i=0x0000_1000, valid, overflow_i=1. Next cycle: flush_o=1, redirect_pc_o=0x80, EPC=0x1000, ExcCode=12, EXL=1.
- Simultaneous events: overflow_i=1 with a SYSCALL word (forced) → ExcCode=12. Then ERET → redirect_pc_o=0x1000, EXL=0.
- Interrupt gating: MTC0 Status=0x0000_0401, then hw_int_i[0]=1 → taken with ExcCode 0. With EXL=1, same stimulus → no flush.
- Bubble and reset: interrupt pending during a bubble → no flush until the first valid cycle. rst_n low during FLUSH → flush_o=0 the same cycle.
- CP0_TIMER_EN: Compare=5 → IP7=1 at Count=5. MTC0 Compare → IP7=0.

Source files
------------

// File: rtl/pcpu_cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, instruction
// decode patterns, Status/Cause field positions and the controller FSM states.
package pcpu_cp0_pkg;

    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [10:0] OP_MTC0       = 11'h204;
    localparam logic [10:0] OP_MFC0       = 11'h200;
    localparam logic [31:0] ERET_WORD     = 32'h4200_0018;
    localparam logic [5:0]  SYSCALL_FUNCT = 6'h0C;

    localparam int ST_IE_BIT  = 0;
    localparam int ST_EXL_BIT = 1;
    localparam int IM_LSB     = 8;
    localparam int SW_IP_LSB  = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_e;

    function automatic logic [31:0] status_word(input logic [7:0] im,
                                                input logic exl,
                                                input logic ie);
        return {16'h0000, im, 6'b000000, exl, ie};
    endfunction

    function automatic logic [31:0] cause_word(input logic [7:0] ip,
                                               input logic [4:0] code);
        return {16'h0000, ip, 1'b0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer; raises IP7 on a match and holds it until Compare is
// rewritten.
module cp0_timer
    import pcpu_cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmp_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ip7_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q, ip7_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ip7_d     = ip7_q;
        // A Compare write acknowledges the timer interrupt even on a match cycle.
        if (cmp_we_i) begin
            compare_d = wdata_i;
            ip7_d     = 1'b0;
        end else if (count_q == compare_q) begin
            ip7_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ip7_o     = ip7_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// Exception/interrupt controller with Status, Cause and EPC; issues a one-cycle
// flush plus PC redirect. Define CP0_TIMER_EN to add the Count/Compare timer.
module cp0_exc_unit
    import pcpu_cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ex_i,
    input  logic [31:0] ir_ex_i,
    input  logic [31:0] pc_ex_i,
    input  logic        overflow_i,
    input  logic [5:0]  hw_int_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    cp0_state_e  state_q, state_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        ip7;
    logic [31:0] count_w, compare_w;
    logic [7:0]  ip;
    logic        is_mtc0, is_mfc0, is_eret, is_syscall;
    logic        run_valid, int_pend, take_evt, do_eret, mtc0_exec;
    logic [4:0]  evt_code;

    assign is_mtc0    = (ir_ex_i[31:21] == OP_MTC0);
    assign is_mfc0    = (ir_ex_i[31:21] == OP_MFC0);
    assign is_eret    = (ir_ex_i == ERET_WORD);
    assign is_syscall = (ir_ex_i[31:26] == 6'd0) && (ir_ex_i[5:0] == SYSCALL_FUNCT);

`ifdef CP0_TIMER_EN
    logic cmp_we;
    assign cmp_we = mtc0_exec && (ir_ex_i[15:11] == CP0_COMPARE);

    cp0_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_we_i  (cmp_we),
        .wdata_i   (wdata_i),
        .count_o   (count_w),
        .compare_o (compare_w),
        .ip7_o     (ip7)
    );
`else
    assign ip7       = hw_int_i[5];
    assign count_w   = '0;
    assign compare_w = '0;
`endif

    // IP[7:2] track the live lines, so a dropped line is never taken late.
    assign ip        = {ip7, hw_int_i[4:0], sw_ip_q};
    assign run_valid = (state_q == ST_RUN) && valid_ex_i;
    assign int_pend  = (|(ip & im_q)) && ie_q && !exl_q;
    assign take_evt  = run_valid && (overflow_i || is_syscall || int_pend);
    assign do_eret   = run_valid && !take_evt && is_eret && exl_q;
    assign mtc0_exec = run_valid && !take_evt && is_mtc0;

    always_comb begin
        evt_code = EXC_INT;
        if (overflow_i)      evt_code = EXC_OV;
        else if (is_syscall) evt_code = EXC_SYS;
    end

    always_comb begin
        state_d       = ST_RUN;
        im_d          = im_q;
        exl_d         = exl_q;
        ie_d          = ie_q;
        sw_ip_d       = sw_ip_q;
        exc_code_d    = exc_code_q;
        epc_d         = epc_q;
        redirect_pc_d = redirect_pc_q;
        if (take_evt) begin
            epc_d         = pc_ex_i;
            exc_code_d    = evt_code;
            exl_d         = 1'b1;
            redirect_pc_d = EXC_VEC;
            state_d       = ST_FLUSH;
        end else if (do_eret) begin
            exl_d         = 1'b0;
            redirect_pc_d = epc_q;
            state_d       = ST_FLUSH;
        end else if (mtc0_exec) begin
            case (ir_ex_i[15:11])
                CP0_STATUS: begin
                    im_d  = wdata_i[IM_LSB +: 8];
                    exl_d = wdata_i[ST_EXL_BIT];
                    ie_d  = wdata_i[ST_IE_BIT];
                end
                CP0_CAUSE: sw_ip_d = wdata_i[SW_IP_LSB +: 2];
                CP0_EPC:   epc_d   = wdata_i;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            im_q          <= '0;
            exl_q         <= 1'b0;
            ie_q          <= 1'b0;
            sw_ip_q       <= '0;
            exc_code_q    <= '0;
            epc_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            im_q          <= im_d;
            exl_q         <= exl_d;
            ie_q          <= ie_d;
            sw_ip_q       <= sw_ip_d;
            exc_code_q    <= exc_code_d;
            epc_q         <= epc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (is_mfc0) begin
            case (ir_ex_i[15:11])
                CP0_STATUS:  rdata_o = status_word(im_q, exl_q, ie_q);
                CP0_CAUSE:   rdata_o = cause_word(ip, exc_code_q);
                CP0_EPC:     rdata_o = epc_q;
                CP0_COUNT:   rdata_o = count_w;
                CP0_COMPARE: rdata_o = compare_w;
                default:     rdata_o = '0;
            endcase
        end
    end

    assign flush_o       = (state_q == ST_FLUSH);
    assign redirect_o    = (state_q == ST_FLUSH);
    assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus a randomized
// run against a behavioural model of the CP0 rules.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex_i;
    logic [31:0] ir_ex_i;
    logic [31:0] pc_ex_i;
    logic        overflow_i;
    logic [5:0]  hw_int_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] W_ADD     = 32'h0109_4020;
    localparam logic [31:0] W_SYSCALL = 32'h0000_000C;
    localparam logic [31:0] W_ERET    = 32'h4200_0018;
`ifdef CP0_TIMER_EN
    localparam logic [31:0] RD_MASK = 32'hFFFF_7FFF;
`else
    localparam logic [31:0] RD_MASK = 32'hFFFF_FFFF;
`endif

    // behavioural model state
    logic [31:0] m_status, m_epc, m_rpc;
    logic [4:0]  m_exc;
    logic [1:0]  m_swip;
    bit          m_in_flush;

    logic [31:0] step_rdata, exp_rdata, v;

    cp0_exc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_ex_i    (valid_ex_i),
        .ir_ex_i       (ir_ex_i),
        .pc_ex_i       (pc_ex_i),
        .overflow_i    (overflow_i),
        .hw_int_i      (hw_int_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mfc0_word(input logic [4:0] idx);
        return {11'h200, 5'd0, idx, 11'd0};
    endfunction

    function automatic logic [31:0] mtc0_word(input logic [4:0] idx);
        return {11'h204, 5'd0, idx, 11'd0};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [5:0] hw);
        case (idx)
            5'd12:   return m_status;
            5'd13:   return {16'h0, hw, m_swip, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 0; m_epc = 0; m_rpc = 0; m_exc = 0; m_swip = 0; m_in_flush = 0;
    endtask

    // One clock of CP0 behaviour, evaluated from the current inputs.
    task automatic model_update();
        int code;
        logic [7:0] ip;
        bit was_flush;
        was_flush  = m_in_flush;
        m_in_flush = 0;
        if (was_flush || !valid_ex_i) return;
        ip   = {hw_int_i, m_swip};
        code = -1;
        if (overflow_i) code = 12;
        else if (ir_ex_i[31:26] == 0 && ir_ex_i[5:0] == 6'd12) code = 8;
        else if ((ip & m_status[15:8]) != 0 && m_status[0] && !m_status[1]) code = 0;
        if (code >= 0) begin
            m_epc = pc_ex_i; m_exc = code[4:0]; m_status[1] = 1'b1;
            m_in_flush = 1; m_rpc = 32'h80;
        end else if (ir_ex_i == W_ERET && m_status[1]) begin
            m_status[1] = 1'b0; m_in_flush = 1; m_rpc = m_epc;
        end else if (ir_ex_i[31:21] == 11'h204) begin
            case (ir_ex_i[15:11])
                5'd12: m_status = wdata_i & 32'h0000_FF03;
                5'd13: m_swip = wdata_i[9:8];
                5'd14: m_epc = wdata_i;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic vld, input logic [31:0] ir, input logic [31:0] pc,
                        input logic ov, input logic [5:0] hw, input logic [31:0] wd);
        valid_ex_i = vld; ir_ex_i = ir; pc_ex_i = pc;
        overflow_i = ov; hw_int_i = hw; wdata_i = wd;
        #1;
        step_rdata = rdata_o;
        exp_rdata  = (ir[31:21] == 11'h200) ? model_read(ir[15:11], hw) : 32'h0;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] idx, output logic [31:0] val);
        ir_ex_i = mfc0_word(idx); valid_ex_i = 1'b0;
        #1;
        val = rdata_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid_ex_i = 0; ir_ex_i = 0; pc_ex_i = 0;
        overflow_i = 0; hw_int_i = 0; wdata_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_rpc: got %h want 0", redirect_pc_o); end
        rd(5'd12, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", v); end
        rd(5'd13, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 0", v); end
        rd(5'd14, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", v); end
    endtask

    task automatic test_overflow();
        do_reset();
        step(1, W_ADD, 32'h1000, 1, 0, 0);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL ov_flush: got %b want 1", flush_o); end
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL ov_redirect: got %b want 1", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h80) begin errors++; $display("FAIL ov_rpc: got %h want 80", redirect_pc_o); end
        rd(5'd14, v);
        checks++; if (v !== 32'h1000) begin errors++; $display("FAIL ov_epc: got %h want 1000", v); end
        rd(5'd13, v);
        checks++; if (v !== 32'h30) begin errors++; $display("FAIL ov_cause: got %h want 30", v); end
        rd(5'd12, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ov_status: got %h want 2", v); end
        // second overflow lands in the FLUSH cycle and must be ignored
        step(1, W_ADD, 32'h2000, 1, 0, 0);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL ov_one_cycle: got %b want 0", flush_o); end
        checks++; if (redirect_pc_o !== 32'h80) begin errors++; $display("FAIL ov_rpc_hold: got %h want 80", redirect_pc_o); end
        rd(5'd14, v);
        checks++; if (v !== 32'h1000) begin errors++; $display("FAIL ov_epc_in_flush: got %h want 1000", v); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, W_SYSCALL, 32'h1000, 1, 0, 0);
        rd(5'd13, v);
        checks++; if (v !== 32'h30) begin errors++; $display("FAIL sim_cause: got %h want 30", v); end
        step(0, 32'h0, 32'h0, 0, 0, 0);
        step(1, W_ERET, 32'h2000, 0, 0, 0);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL eret_flush: got %b want 1", flush_o); end
        checks++; if (redirect_pc_o !== 32'h1000) begin errors++; $display("FAIL eret_rpc: got %h want 1000", redirect_pc_o); end
        rd(5'd12, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL eret_status: got %h want 0", v); end
        step(0, 32'h0, 32'h0, 0, 0, 0);
        step(1, W_ERET, 32'h3000, 0, 0, 0);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL eret_noop: got %b want 0", flush_o); end
        step(1, W_SYSCALL, 32'h0200, 0, 0, 0);
        rd(5'd13, v);
        checks++; if (v !== 32'h20) begin errors++; $display("FAIL sys_cause: got %h want 20", v); end
    endtask

    task automatic test_interrupt();
        do_reset();
        step(1, mtc0_word(5'd12), 32'h100, 0, 0, 32'h0000_0401);
        rd(5'd12, v);
        checks++; if (v !== 32'h401) begin errors++; $display("FAIL int_status_wr: got %h want 401", v); end
        step(1, W_ADD, 32'h300, 0, 6'h01, 0);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL int_taken: got %b want 1", flush_o); end
        rd(5'd13, v);
        checks++; if (v !== 32'h400) begin errors++; $display("FAIL int_cause: got %h want 400", v); end
        rd(5'd14, v);
        checks++; if (v !== 32'h300) begin errors++; $display("FAIL int_epc: got %h want 300", v); end
        step(0, 32'h0, 32'h0, 0, 6'h01, 0);
        step(1, W_ADD, 32'h80, 0, 6'h01, 0);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL int_exl_mask: got %b want 0", flush_o); end
        // software interrupt through Cause IP[9:8]; other Cause bits ignored
        do_reset();
        step(1, mtc0_word(5'd13), 32'h100, 0, 0, 32'hFFFF_FFFF);
        rd(5'd13, v);
        checks++; if (v !== 32'h300) begin errors++; $display("FAIL swip_cause: got %h want 300", v); end
        step(1, mtc0_word(5'd12), 32'h104, 0, 0, 32'h0000_0201);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL swip_mtc0_noflush: got %b want 0", flush_o); end
        step(1, W_ADD, 32'h108, 0, 0, 0);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL swip_taken: got %b want 1", flush_o); end
`ifndef CP0_TIMER_EN
        hw_int_i = 6'h20;
        rd(5'd13, v);
        checks++; if (v !== 32'h8300) begin errors++; $display("FAIL ip7_mirror: got %h want 8300", v); end
        rd(5'd9, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_absent: got %h want 0", v); end
`endif
    endtask

    task automatic test_bubble_reset();
        do_reset();
        step(1, mtc0_word(5'd12), 32'h100, 0, 0, 32'h0000_0401);
        step(0, W_ADD, 32'h200, 0, 6'h01, 0);
        step(0, W_ADD, 32'h200, 0, 6'h01, 0);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL bubble_wait: got %b want 0", flush_o); end
        step(1, W_ADD, 32'h204, 0, 6'h00, 0);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL int_dropped: got %b want 0", flush_o); end
        step(0, W_ADD, 32'h208, 0, 6'h01, 0);
        step(1, W_ADD, 32'h20C, 0, 6'h01, 0);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL bubble_then_valid: got %b want 1", flush_o); end
        rd(5'd14, v);
        checks++; if (v !== 32'h20C) begin errors++; $display("FAIL bubble_epc: got %h want 20c", v); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rst_in_flush: got %b want 0", flush_o); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL rst_in_flush_redir: got %b want 0", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rst_in_flush_rpc: got %h want 0", redirect_pc_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, mtc0_word(5'd12), 32'h10, 0, 0, 32'h0000_0002);
        step(1, mtc0_word(5'd14), 32'h14, 0, 0, 32'h0000_4444);
        step(1, W_ERET, 32'h18, 0, 0, 0);
        checks++; if (redirect_pc_o !== 32'h4444) begin errors++; $display("FAIL b2b_eret_rpc: got %h want 4444", redirect_pc_o); end
        step(1, mtc0_word(5'd14), 32'h1C, 0, 0, 32'h5555);
        rd(5'd14, v);
        checks++; if (v !== 32'h4444) begin errors++; $display("FAIL b2b_mtc0_in_flush: got %h want 4444", v); end
        step(1, W_ADD, 32'h4444, 1, 0, 0);
        checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h80) begin
            errors++; $display("FAIL b2b_ov_after_flush: got %b/%h want 1/80", flush_o, redirect_pc_o);
        end
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        bit found;
        do_reset();
        step(1, mtc0_word(5'd11), 32'h10, 0, 0, 32'd5);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            rd(5'd13, v);
            if (v[15]) found = 1;
            else step(0, 32'h0, 32'h0, 0, 0, 0);
        end
        checks++; if (!found) begin errors++; $display("FAIL timer_ip7: got 0 want 1 within 20 cycles"); end
        rd(5'd9, v);
        checks++; if (v !== 32'd6) begin errors++; $display("FAIL timer_count_at_ip7: got %0d want 6", v); end
        rd(5'd11, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL timer_compare: got %0d want 5", v); end
        step(1, mtc0_word(5'd11), 32'h14, 0, 6'h20, 32'd1000);
        rd(5'd13, v);
        checks++; if (v[15] !== 1'b0) begin errors++; $display("FAIL timer_ip7_clear: got %b want 0", v[15]); end
    endtask
`endif

    task automatic test_random();
        logic [4:0] idx_tab [7];
        logic [31:0] r, ir, wd;
        logic [5:0] hw;
        logic [4:0] idx;
        logic vld, ov;
        int sel;
        idx_tab = '{5'd0, 5'd3, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            sel = $urandom_range(0, 9);
            idx = idx_tab[$urandom_range(0, 6)];
            wd  = $urandom();
`ifdef CP0_TIMER_EN
            if (idx == 5'd12) wd = wd & 32'hFFFF_7FFF;
`endif
            case (sel)
                0, 1, 2: ir = {6'h08, r[25:0]};
                3:       ir = W_SYSCALL;
                4:       ir = W_ERET;
                5, 6:    ir = mtc0_word(idx);
                7, 8:    ir = mfc0_word(idx);
                default: ir = 32'h0;
            endcase
            vld = ($urandom_range(0, 3) != 0);
            ov  = ($urandom_range(0, 15) == 0);
            hw  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
            step(vld, ir, $urandom() & 32'hFFFF_FFFC, ov, hw, wd);
            if (sel == 7 || sel == 8) begin
                checks++;
                if ((step_rdata & RD_MASK) !== (exp_rdata & RD_MASK)) begin
                    errors++; $display("FAIL rnd_mfc0 idx %0d iter %0d: got %h want %h", idx, n, step_rdata, exp_rdata);
                end
            end
            checks++; if (flush_o !== m_in_flush) begin errors++; $display("FAIL rnd_flush iter %0d: got %b want %b", n, flush_o, m_in_flush); end
            checks++; if (redirect_o !== m_in_flush) begin errors++; $display("FAIL rnd_redirect iter %0d: got %b want %b", n, redirect_o, m_in_flush); end
            checks++; if (redirect_pc_o !== m_rpc) begin errors++; $display("FAIL rnd_rpc iter %0d: got %h want %h", n, redirect_pc_o, m_rpc); end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_simultaneous();
        test_interrupt();
        test_bubble_reset();
        test_back_to_back();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
